// File: rtl/fp_norm_round.sv
// Normalize/round stage after the 20-bit mantissa adder: renormalize, RNE round, pack, flag.
// Ports: clk/rst_n, in_valid/in_ready + sum/cout/exp/sign in, out_valid/out_ready + res_*/zero/ovf/unf out. Macro: NORM_FAST_SHIFT_EN.
module fp_norm_round #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      sum,
  input  logic             cout,
  input  logic [EXP_W-1:0] exp,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_sign,
  output logic [EXP_W-1:0] res_exp,
  output logic [14:0]      res_frac,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [EXP_W:0] ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

  state_t         state;
  logic [19:0]    m;
  logic [EXP_W:0] e;
  logic           st;
  logic           sign_q;

  logic           lsb, g, s, up;
  logic [16:0]    r;
  logic [EXP_W:0] er;
  logic           hid;
  logic [14:0]    fr;
  logic           stop;

  assign in_ready = (state == IDLE);

  // Shifting also stops once e is saturated so a load-time overflow survives.
  assign stop = (m == 20'd0) || m[19] || (e <= ONE) || (e >= EMAX);

  always_comb begin
    lsb = m[4];
    g   = m[3];
    s   = (|m[2:0]) | st;
    up  = g & (s | lsb);
    r   = {1'b0, m[19:4]} + {16'd0, up};
    if (r[16]) begin
      hid = 1'b1;
      fr  = 15'd0;
      er  = e + ONE;
    end else begin
      hid = r[15];
      fr  = r[14:0];
      er  = e;
    end
  end

`ifdef NORM_FAST_SHIFT_EN
  logic [4:0]     lz;
  logic           found;
  logic [EXP_W:0] elim;
  logic [4:0]     sh;

  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 19; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lz    = lz + 5'd1;
      end
    end
    // Never shift below the minimum exponent of 1.
    elim = e - ONE;
    if (elim < {{(EXP_W-4){1'b0}}, lz}) sh = elim[4:0];
    else                                sh = lz;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      e         <= '0;
      st        <= 1'b0;
      sign_q    <= 1'b0;
      out_valid <= 1'b0;
      res_sign  <= 1'b0;
      res_exp   <= '0;
      res_frac  <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign;
            if (cout) begin
              m  <= {1'b1, sum[19:1]};
              st <= sum[0];
              e  <= {1'b0, exp} + ONE;
            end else begin
              m  <= sum;
              st <= 1'b0;
              e  <= (exp == '0) ? ONE : {1'b0, exp};
            end
            state <= NORM;
          end
        end
        NORM: begin
          if (stop) begin
            state <= ROUND;
          end else begin
`ifdef NORM_FAST_SHIFT_EN
            m     <= m << sh;
            e     <= e - {{(EXP_W-4){1'b0}}, sh};
            state <= ROUND;
`else
            m <= {m[18:0], 1'b0};
            e <= e - ONE;
`endif
          end
        end
        ROUND: begin
          res_sign  <= sign_q;
          out_valid <= 1'b1;
          state     <= DONE;
          if ((m == 20'd0) && !st) begin
            zero     <= 1'b1;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            res_exp  <= '0;
            res_frac <= '0;
          end else if (er >= EMAX) begin
            zero     <= 1'b0;
            ovf      <= 1'b1;
            unf      <= 1'b0;
            res_exp  <= '1;
            res_frac <= '0;
          end else begin
            zero     <= 1'b0;
            ovf      <= 1'b0;
            unf      <= !hid && (fr != 15'd0);
            res_exp  <= hid ? er[EXP_W-1:0] : '0;
            res_frac <= fr;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: latency, rounding, special cases, stall, reset abort.
// Expected values are hand-computed per vector.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] sum = '0;
  logic        cout = 1'b0;
  logic [7:0]  exp_i = '0;
  logic        sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [14:0] res_frac;
  logic        zero, ovf, unf;

  int ncmp = 0;
  int nerr = 0;

  fp_norm_round #(.EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .exp(exp_i), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_exp(res_exp), .res_frac(res_frac),
    .zero(zero), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] xp);
    ncmp++;
    assert (obs === xp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, xp);
    end
  endtask

  task automatic run(input string tag, input logic c,
                     input logic [19:0] s, input logic [7:0] ex,
                     input logic sg, input int lat,
                     input logic [7:0] xe, input logic [14:0] xf,
                     input logic xz, input logic xo, input logic xu,
                     input int stall);
    int n;
    int xl;
    xl = lat;
`ifdef NORM_FAST_SHIFT_EN
    xl = 2;
`endif
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/rdy_pre"}, in_ready, 1);
    cout = c; sum = s; exp_i = ex; sign = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "/rdy_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/lat"}, n, xl);
    chk({tag, "/sign"}, res_sign, sg);
    chk({tag, "/exp"}, res_exp, xe);
    chk({tag, "/frac"}, res_frac, xf);
    chk({tag, "/flags"}, {zero, ovf, unf}, {xz, xo, xu});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "/stall_v"}, out_valid, 1);
      chk({tag, "/stall_e"}, res_exp, xe);
      chk({tag, "/stall_f"}, res_frac, xf);
      chk({tag, "/stall_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/drain_v"}, out_valid, 0);
    chk({tag, "/drain_rdy"}, in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst/valid", out_valid, 0);
    chk("rst/outs", {res_sign, res_exp, res_frac, zero, ovf, unf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst/rdy", in_ready, 1);

    // tag, cout, sum, exp, sign, lat, exp, frac, z, o, u, stall
    run("cout0", 1, 20'h00000, 8'd10, 0, 2, 8'd11, 15'h0000, 0, 0, 0, 0);
    run("stall", 0, 20'h80000, 8'd100, 1, 2, 8'd100, 15'h0000, 0, 0, 0, 5);
    run("shift15", 0, 20'h00010, 8'd100, 0, 17, 8'd85, 15'h0000, 0, 0, 0, 0);
    run("tie_odd", 0, 20'h80018, 8'd50, 1, 2, 8'd50, 15'h0002, 0, 0, 0, 0);
    run("tie_even", 0, 20'h80008, 8'd50, 0, 2, 8'd50, 15'h0000, 0, 0, 0, 0);
    run("rnd_carry", 0, 20'hFFFF8, 8'd20, 0, 2, 8'd21, 15'h0000, 0, 0, 0, 0);
    run("cout_stk", 1, 20'h00011, 8'd10, 0, 2, 8'd11, 15'h0001, 0, 0, 0, 0);
    run("zero", 0, 20'h00000, 8'd5, 0, 2, 8'd0, 15'h0000, 1, 0, 0, 0);
    run("ovf", 1, 20'h12345, 8'd254, 1, 2, 8'd255, 15'h0000, 0, 1, 0, 0);
    run("subn", 0, 20'h00100, 8'd3, 0, 4, 8'd0, 15'h0040, 0, 0, 1, 0);
    run("exp0", 0, 20'h40000, 8'd0, 0, 2, 8'd0, 15'h4000, 0, 0, 1, 0);
    run("sub2norm", 0, 20'h7FFF8, 8'd1, 0, 2, 8'd1, 15'h0000, 0, 0, 0, 0);

    // Abort mid-operation: previous result outputs are nonzero here.
    cout = 1'b0; sum = 20'h00010; exp_i = 8'd100; sign = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort/valid", out_valid, 0);
    chk("abort/outs", {res_sign, res_exp, res_frac, zero, ovf, unf}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort/rdy", in_ready, 1);
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort/no_res", out_valid, 0);
    end
    run("post_rst", 0, 20'h80018, 8'd50, 0, 2, 8'd50, 15'h0002, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
